// File: rtl/dac8811_arbiter.sv
// dac8811_arbiter
// Round-robin sharing of one DAC8811 serial port between NREQ requesters.
// A granted 16-bit code is shifted MSB-first on CS/SCLK/SDI; the winner
// receives a one-cycle ack in the cycle CS rises (the DAC load moment).
//
// Handshake: req[i] is a level request. The requester keeps it high until it
// sees ack[i], and each ack pulse means exactly one frame was loaded. A request
// withdrawn before its grant produces no frame; one withdrawn after its grant
// still completes and is acked. data[16i+15:16i] is sampled only in the grant
// cycle, so it may change freely afterwards.

module dac8811_arbiter #(
    parameter int NREQ    = 4,
    parameter int CLK_DIV = 11,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   data,
    output logic [NREQ-1:0]      ack,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 CS,
    output logic                 SCLK,
    output logic                 SDI
);

    // Phase counter must reach 2H-1 (the GAP length).
    localparam int CW = $clog2(2 * CLK_DIV + 1);
    localparam logic [CW-1:0] H_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        LOAD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [3:0]      bit_cnt;
    logic [15:0]     shreg;
    logic [IDW-1:0]  rr_ptr;

    logic            found;
    logic [IDW-1:0]  win;
    logic [15:0]     win_data;
    int              cand;

    // Round-robin search starting at rr_ptr; also selects the winner's code.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        cand     = 0;
        win_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req[IDW'(cand)]) begin
                found = 1'b1;
                win   = IDW'(cand);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (IDW'(k) == win) begin
                win_data = data[16*k +: 16];
            end
        end
    end

    // Frame sequencer: grant, SETUP, 16 bit periods, LOAD, GAP; all pins registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rr_ptr   <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            ack      <= '0;
            CS       <= 1'b1;
            SCLK     <= 1'b0;
            SDI      <= 1'b0;
        end else begin
            // ack is a single-cycle pulse; only the SHIFT->LOAD step raises it.
            ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        shreg    <= win_data;
                        grant_id <= win;
                        rr_ptr   <= (win == ID_LAST) ? '0 : win + 1'b1;
                        busy     <= 1'b1;
                        CS       <= 1'b0;
                        SCLK     <= 1'b0;
                        SDI      <= win_data[15];
                        cnt      <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == H_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        SCLK    <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != H_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (SCLK) begin
                            // Falling edge: present the next bit (zero after bit 0).
                            SCLK  <= 1'b0;
                            SDI   <= shreg[14];
                            shreg <= {shreg[14:0], 1'b0};
                        end else if (bit_cnt == 4'd15) begin
                            // Sixteenth low phase done: CS rises, DAC loads, winner acked.
                            CS            <= 1'b1;
                            SDI           <= 1'b0;
                            ack[grant_id] <= 1'b1;
                            state         <= LOAD;
                        end else begin
                            SCLK    <= 1'b1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= GAP;
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    busy  <= 1'b0;
                    CS    <= 1'b1;
                    SCLK  <= 1'b0;
                    SDI   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac8811_arbiter.sv
// Bench for dac8811_arbiter: instance 0 runs H=2, instance 1 runs H=1.
// A waveform-level model predicts every output cycle; a frame monitor
// checks shifted words and ack order against an expected queue.

module tb_dac8811_arbiter;

  localparam int NR = 4;

  typedef struct packed {
    logic       cs;
    logic       sclk;
    logic       sdi;
    logic       care;
    logic       busy;
    logic [3:0] ack;
  } cyc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a  [2];
  logic [3:0]  req_a  [2];
  logic [63:0] data_a [2];
  logic [3:0]  ack_a  [2];
  logic        busy_a [2];
  logic [1:0]  gid_a  [2];
  logic        cs_a   [2];
  logic        sclk_a [2];
  logic        sdi_a  [2];

  dac8811_arbiter #(.NREQ(4), .CLK_DIV(2)) dut0 (
    .clk(clk), .rst(rst_a[0]), .req(req_a[0]), .data(data_a[0]),
    .ack(ack_a[0]), .busy(busy_a[0]), .grant_id(gid_a[0]),
    .CS(cs_a[0]), .SCLK(sclk_a[0]), .SDI(sdi_a[0])
  );

  dac8811_arbiter #(.NREQ(4), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst_a[1]), .req(req_a[1]), .data(data_a[1]),
    .ack(ack_a[1]), .busy(busy_a[1]), .grant_id(gid_a[1]),
    .CS(cs_a[1]), .SCLK(sclk_a[1]), .SDI(sdi_a[1])
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  cyc_t       mq0[$];
  cyc_t       mq1[$];
  cyc_t       cur  [2];
  int         mptr [2];
  logic [1:0] mgid [2];
  int         mw;

  // frame-level expectations {id, word}
  logic [17:0] exp_q0[$];
  logic [17:0] exp_q1[$];

  function automatic int hof(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic cyc_t mk(input logic cs, input logic sclk, input logic sdi,
                              input logic care, input logic busy, input logic [3:0] ack);
    cyc_t e;
    e.cs = cs; e.sclk = sclk; e.sdi = sdi; e.care = care; e.busy = busy; e.ack = ack;
    return e;
  endfunction

  function automatic cyc_t idle_e();
    return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
  endfunction

  function automatic int qsz(input int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic push_e(input int i, input cyc_t e);
    if (i == 0) mq0.push_back(e);
    else mq1.push_back(e);
  endtask

  task automatic pop_e(input int i, output cyc_t e);
    if (i == 0) e = mq0.pop_front();
    else e = mq1.pop_front();
  endtask

  // Whole frame as seen on the pins, from the cycle after the grant to the next IDLE.
  task automatic build_frame(input int i, input int w, input logic [15:0] word);
    int   h;
    logic b;
    h = hof(i);
    for (int c = 0; c < h; c++) push_e(i, mk(1'b0, 1'b0, word[15], 1'b1, 1'b1, 4'b0));
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < h; c++) push_e(i, mk(1'b0, 1'b1, word[15-k], 1'b1, 1'b1, 4'b0));
      b = 1'b0;
      if (k < 15) b = word[14-k];
      for (int c = 0; c < h; c++) push_e(i, mk(1'b0, 1'b0, b, (k < 15), 1'b1, 4'b0));
    end
    push_e(i, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'(1 << w)));
    for (int c = 0; c < 2*h; c++) push_e(i, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0));
    push_e(i, idle_e());
  endtask

  // model advance on each rising edge, from the inputs only
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_a[i]) begin
        if (i == 0) mq0.delete();
        else mq1.delete();
        mptr[i] = 0;
        mgid[i] = 2'd0;
        cur[i]  = idle_e();
      end else begin
        if (qsz(i) == 0 && req_a[i] != 4'b0) begin
          mw = -1;
          for (int k = 0; k < NR; k++)
            if (mw < 0 && req_a[i][(mptr[i] + k) % NR]) mw = (mptr[i] + k) % NR;
          build_frame(i, mw, data_a[i][16*mw +: 16]);
          mgid[i] = 2'(mw);
          mptr[i] = (mw + 1) % NR;
        end
        if (qsz(i) != 0) pop_e(i, cur[i]);
        else cur[i] = idle_e();
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    cyc_t       e;
    logic [1:0] eg;
    for (int i = 0; i < 2; i++) begin
      e  = rst_a[i] ? idle_e() : cur[i];
      eg = rst_a[i] ? 2'd0 : mgid[i];
      checks++;
      if (cs_a[i] !== e.cs || sclk_a[i] !== e.sclk || (e.care && sdi_a[i] !== e.sdi) ||
          ack_a[i] !== e.ack || busy_a[i] !== e.busy || gid_a[i] !== eg) begin
        errors++;
        $display("FAIL cycle_dut%0d t=%0t got cs=%b sclk=%b sdi=%b ack=%b busy=%b gid=%0d want cs=%b sclk=%b sdi=%b(care=%b) ack=%b busy=%b gid=%0d",
                 i, $time, cs_a[i], sclk_a[i], sdi_a[i], ack_a[i], busy_a[i], gid_a[i],
                 e.cs, e.sclk, e.sdi, e.care, e.ack, e.busy, eg);
      end
    end
  end

  // ---------------- frame monitor / scoreboard ----------------
  int          cslow [2];
  int          hicnt [2];
  int          rises [2];
  int          last_hi [2];
  int          last_lo [2];
  logic [15:0] word_s [2];
  logic        pcs [2];
  logic        psclk [2];

  task automatic frame_check(input int i);
    logic [17:0] e;
    if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_ack dut%0d got ack=%b word=%h want no ack", i, ack_a[i], word_s[i]);
    end else begin
      if (i == 0) e = exp_q0.pop_front();
      else e = exp_q1.pop_front();
      checks++;
      if (ack_a[i] !== 4'(1 << e[17:16]) || word_s[i] !== e[15:0]) begin
        errors++;
        $display("FAIL frame_dut%0d got ack=%b word=%h want ack=%b word=%h",
                 i, ack_a[i], word_s[i], 4'(1 << e[17:16]), e[15:0]);
      end
      checks++;
      if (cslow[i] != 33 * hof(i)) begin
        errors++;
        $display("FAIL cs_low_len_dut%0d got %0d want %0d", i, cslow[i], 33 * hof(i));
      end
      checks++;
      if (rises[i] != 16) begin
        errors++;
        $display("FAIL sclk_rises_dut%0d got %0d want 16", i, rises[i]);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_a[i]) begin
        cslow[i] = 0; rises[i] = 0; word_s[i] = 16'h0; hicnt[i] = 0;
        pcs[i] = 1'b1; psclk[i] = 1'b0;
      end else begin
        if (!cs_a[i]) begin
          if (pcs[i]) begin
            last_hi[i] = hicnt[i]; cslow[i] = 0; rises[i] = 0;
          end
          cslow[i]++;
          if (sclk_a[i] && !psclk[i]) begin
            rises[i]++;
            word_s[i] = {word_s[i][14:0], sdi_a[i]};
          end
        end else begin
          if (!pcs[i]) begin
            last_lo[i] = cslow[i]; hicnt[i] = 0;
          end
          hicnt[i]++;
        end
        if (ack_a[i] != 4'b0) frame_check(i);
        pcs[i] = cs_a[i]; psclk[i] = sclk_a[i];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_ack(input int i, input int b, input int max);
    for (int t = 0; t < max; t++) begin
      @(posedge clk); #2;
      if (ack_a[i][b]) return;
    end
    checks++; errors++;
    $display("FAIL wait_ack_dut%0d_bit%0d got no ack want ack within %0d cycles", i, b, max);
  endtask

  task automatic wait_idle(input int i, input int max);
    for (int t = 0; t < max; t++) begin
      @(posedge clk); #2;
      if (!busy_a[i]) return;
    end
    checks++; errors++;
    $display("FAIL wait_idle_dut%0d got busy=1 want busy=0 within %0d cycles", i, max);
  endtask

  task automatic wait_cs_low(input int i, input int max);
    for (int t = 0; t < max; t++) begin
      @(posedge clk); #2;
      if (!cs_a[i]) return;
    end
    checks++; errors++;
    $display("FAIL wait_cs_low_dut%0d got cs=1 want cs=0 within %0d cycles", i, max);
  endtask

  task automatic do_reset(input int i);
    rst_a[i] = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_a[i] = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    logic p;
    for (int i = 0; i < 2; i++) begin
      rst_a[i] = 1'b1; req_a[i] = 4'b0; data_a[i] = 64'h0;
      cur[i] = idle_e(); mptr[i] = 0; mgid[i] = 2'd0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cs", int'(cs_a[0]), 1);
    chk("rst_sclk", int'(sclk_a[0]), 0);
    chk("rst_sdi", int'(sdi_a[0]), 0);
    chk("rst_ack", int'(ack_a[0]), 0);
    chk("rst_busy", int'(busy_a[0]), 0);
    chk("rst_gid", int'(gid_a[0]), 0);
    rst_a[0] = 1'b0; rst_a[1] = 1'b0;
    @(posedge clk); #2;

    // single requester 0, code 0xA5C3
    data_a[0][15:0] = 16'hA5C3;
    req_a[0] = 4'b0001;
    exp_q0.push_back({2'd0, 16'hA5C3});
    wait_ack(0, 0, 200);
    chk("a_gid", int'(gid_a[0]), 0);
    req_a[0] = 4'b0;
    wait_idle(0, 50);
    chk("a_cs_low_len", last_lo[0], 66);

    // req0 and req2 together after reset
    do_reset(0);
    data_a[0] = {16'h0F0F, 16'h5A3C, 16'h1111, 16'hA5C3};
    req_a[0] = 4'b0101;
    exp_q0.push_back({2'd0, 16'hA5C3});
    exp_q0.push_back({2'd2, 16'h5A3C});
    wait_ack(0, 0, 200);
    req_a[0][0] = 1'b0;
    wait_ack(0, 2, 200);
    chk("b_cs_high_between", last_hi[0], 6);
    req_a[0][2] = 1'b0;
    wait_idle(0, 50);

    // all four held: 0,1,2,3,0,1
    do_reset(0);
    data_a[0] = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    req_a[0] = 4'b1111;
    exp_q0.push_back({2'd0, 16'h0000});
    exp_q0.push_back({2'd1, 16'h1111});
    exp_q0.push_back({2'd2, 16'h2222});
    exp_q0.push_back({2'd3, 16'h3333});
    exp_q0.push_back({2'd0, 16'h0000});
    exp_q0.push_back({2'd1, 16'h1111});
    for (int k = 0; k < 6; k++) wait_ack(0, k % 4, 200);
    req_a[0] = 4'b0;
    wait_idle(0, 50);

    // data1 changes one cycle after the grant; frame keeps 0x1234
    data_a[0][31:16] = 16'h1234;
    req_a[0] = 4'b0010;
    exp_q0.push_back({2'd1, 16'h1234});
    wait_cs_low(0, 20);
    chk("d_gid", int'(gid_a[0]), 1);
    @(posedge clk); #2;
    data_a[0][31:16] = 16'hFFFF;
    wait_ack(0, 1, 200);
    req_a[0] = 4'b0;
    wait_idle(0, 50);

    // reset after the 7th SCLK rise, requester 3 keeps requesting
    data_a[0][63:48] = 16'hC3A5;
    req_a[0] = 4'b1000;
    n = 0; p = 1'b0;
    for (int t = 0; t < 200 && n < 7; t++) begin
      @(posedge clk); #2;
      if (!cs_a[0] && sclk_a[0] && !p) n++;
      p = sclk_a[0];
    end
    chk("e_rises_before_rst", n, 7);
    rst_a[0] = 1'b1;
    #1;
    chk("e_rst_cs", int'(cs_a[0]), 1);
    chk("e_rst_sclk", int'(sclk_a[0]), 0);
    chk("e_rst_sdi", int'(sdi_a[0]), 0);
    chk("e_rst_ack", int'(ack_a[0]), 0);
    chk("e_rst_busy", int'(busy_a[0]), 0);
    chk("e_rst_gid", int'(gid_a[0]), 0);
    @(posedge clk); #2;
    rst_a[0] = 1'b0;
    exp_q0.push_back({2'd3, 16'hC3A5});
    wait_ack(0, 3, 200);
    req_a[0] = 4'b0;
    wait_idle(0, 50);

    // H=1 instance, code 0x8001
    data_a[1][15:0] = 16'h8001;
    req_a[1] = 4'b0001;
    exp_q1.push_back({2'd0, 16'h8001});
    wait_ack(1, 0, 100);
    req_a[1] = 4'b0;
    wait_idle(1, 20);
    chk("f_cs_low_len", last_lo[1], 33);

    repeat (5) @(posedge clk);
    #2;
    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish want finish before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
